// File: rtl/awgn_pkg.sv
// Shared types, Q-format widths and arithmetic helpers for the AWGN stream controller.
package awgn_pkg;

    typedef enum logic [1:0] {IDLE, SEED, FILL, RUN} state_t;

    localparam int unsigned G_W     = 16;
    localparam int unsigned F_W     = 17;
    localparam int unsigned SIGMA_W = 16;
    localparam int unsigned P_W     = G_W + F_W + 1;      // g * unsigned f, Q5.28
    localparam int unsigned Q_W     = P_W + SIGMA_W + 1;  // p * unsigned sigma, Q9.40 plus sign headroom

    // Right shift that takes the Q9.40 product down to Q5.(out_w-5).
    function automatic int unsigned shift_of(input int unsigned out_w);
        return 40 - (out_w - 5);
    endfunction

    function automatic logic signed [Q_W-1:0] sat_clamp(
        input  logic signed [Q_W-1:0] v,
        input  int unsigned           w,
        output logic                  hit
    );
        logic signed [Q_W-1:0] hi;
        logic signed [Q_W-1:0] lo;
        logic signed [Q_W-1:0] res;
        hi  = (Q_W'(1) << (w - 1)) - Q_W'(1);
        lo  = ~hi;
        hit = 1'b1;
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end else begin
            res = v;
            hit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/awgn_fifo.sv
// First-word-fall-through FIFO with occupancy count; head word is read straight from storage.
module awgn_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW + 1)'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/awgn_stream_ctrl.sv
// Box-Muller AWGN output controller: core sequencing, sigma scaling with rounding and
// saturation, credit-based core stall and FWFT output buffering.
module awgn_stream_ctrl
    import awgn_pkg::*;
#(
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PIPE_LAT   = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [SIGMA_W-1:0]       sigma,
    input  logic signed [G_W-1:0]    core_g0,
    input  logic signed [G_W-1:0]    core_g1,
    input  logic [F_W-1:0]           core_f,
    output logic                     core_ce,
    output logic                     seed_load,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  x0,
    output logic signed [OUT_W-1:0]  x1,
    output logic [15:0]              sat_cnt,
    output logic                     busy
);

    localparam int unsigned S     = shift_of(OUT_W);
    localparam int unsigned CW    = $clog2(PIPE_LAT + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [Q_W-1:0] RND = Q_W'(1) << (S - 1);

    state_t               state;
    logic [CW-1:0]        fill_cnt;
    logic [SIGMA_W-1:0]   sigma_q;

    logic                 v1;
    logic                 v2;
    logic signed [P_W-1:0] p0_q;
    logic signed [P_W-1:0] p1_q;
    logic signed [OUT_W-1:0] x0_s;
    logic signed [OUT_W-1:0] x1_s;

    logic signed [Q_W-1:0] q0;
    logic signed [Q_W-1:0] q1;
    logic signed [Q_W-1:0] r0;
    logic signed [Q_W-1:0] r1;
    logic signed [OUT_W-1:0] x0_n;
    logic signed [OUT_W-1:0] x1_n;
    logic                 hit0;
    logic                 hit1;
    logic [16:0]          sat_sum;

    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       inflight;
    logic                 credit_ok;
    logic                 capture;
    logic [2*OUT_W-1:0]   fifo_dout;

    // Credit counts stage-valid pairs too, so everything in flight has a guaranteed slot.
    assign inflight  = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(v1) + (CNT_W + 1)'(v2);
    assign credit_ok = inflight < (CNT_W + 1)'(FIFO_DEPTH);
    assign core_ce   = (state == FILL) || ((state == RUN) && credit_ok);
    assign capture   = (state == RUN) && credit_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            seed_load <= 1'b0;
            fill_cnt  <= '0;
            sigma_q   <= 16'h1000;
        end else begin
            seed_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= SEED;
                        seed_load <= 1'b1;
                        sigma_q   <= sigma;
                    end
                end
                SEED: begin
                    fill_cnt <= '0;
                    state    <= en ? FILL : IDLE;
                end
                FILL: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (fill_cnt == CW'(PIPE_LAT - 1)) begin
                        state <= RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        q0      = p0_q * $signed({1'b0, sigma_q});
        q1      = p1_q * $signed({1'b0, sigma_q});
        r0      = (q0 + RND) >>> S;
        r1      = (q1 + RND) >>> S;
        hit0    = 1'b0;
        hit1    = 1'b0;
        x0_n    = OUT_W'(sat_clamp(r0, OUT_W, hit0));
        x1_n    = OUT_W'(sat_clamp(r1, OUT_W, hit1));
        sat_sum = {1'b0, sat_cnt} + 17'(hit0) + 17'(hit1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            p0_q    <= '0;
            p1_q    <= '0;
            x0_s    <= '0;
            x1_s    <= '0;
            sat_cnt <= '0;
        end else begin
            v1 <= capture;
            v2 <= v1;
            if (capture) begin
                p0_q <= core_g0 * $signed({1'b0, core_f});
                p1_q <= core_g1 * $signed({1'b0, core_f});
            end
            if (v1) begin
                x0_s    <= x0_n;
                x1_s    <= x1_n;
                sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

    awgn_fifo #(
        .WIDTH (2 * OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (v2),
        .din   ({x0_s, x1_s}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign x0        = fifo_dout[2*OUT_W-1:OUT_W];
    assign x1        = fifo_dout[OUT_W-1:0];
    assign busy      = (state != IDLE) || v1 || v2 || out_valid;

endmodule

// File: doc/awgn_stream_ctrl.md
# awgn_stream_ctrl

Parametrised output controller for the Box-Muller AWGN generator. Sequences seed load and pipeline fill of the transcendental core (URNG, log, sqrt and sin/cos units), discards fill garbage, and stalls the core through a clock enable. Each core sample pair (g0·f, g1·f) is scaled by a programmable sigma with rounding and saturation. Results are buffered in a FIFO and presented as a valid/ready stream, one x0/x1 pair per beat.

## Interface
- OUT_W, 16: output sample width, signed, format Q5.(OUT_W-5); range 8..24.
- FIFO_DEPTH, 8: entries, power of two, ≥4.
- PIPE_LAT, 10: core latency in core_ce edges from seed_load to first valid core output; ≥1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  level; high = generate, low = stop.
- sigma  in  16  unsigned Q4.12 scale; sampled only on IDLE→SEED.
- core_g0, core_g1  in  16  signed Q1.15 sin/cos outputs of core.
- core_f  in  17  unsigned Q4.13 sqrt output of core.
- core_ce  out  1  core pipeline clock enable.
- seed_load  out  1  one-cycle pulse; core reloads URNG seeds.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts a beat when out_valid && out_ready.
- x0, x1  out  OUT_W  head-of-FIFO samples.
- sat_cnt  out  16  saturating count of clamped samples, per channel.
- busy  out  1  state≠IDLE, or data in flight or in FIFO.

## Operation
- FSM states: IDLE, SEED, FILL, RUN.
  - IDLE→SEED when en=1; latch sigma.
  - SEED lasts one cycle with seed_load=1, then goes to FILL with fill counter=0.
  - FILL: core_ce=1; counter increments per cycle; →RUN after PIPE_LAT cycles. No captures occur in FILL.
  - RUN: core_ce = (fifo_count + v1 + v2 < FIFO_DEPTH). v1/v2 are the stage-valid flags. A capture happens on every RUN edge with core_ce=1.
  - en=0 in SEED, FILL or RUN → IDLE next cycle; core_ce=0 from that cycle.
- In-flight stages complete and write the FIFO even after a stop. The FIFO keeps draining.
- Every start reseeds, so identical seeds and sigma give an identical output sequence.
- Arithmetic, per channel:
  - Stage 1: p = g·f, signed 34-bit, Q5.28.
  - Stage 2: q = p·sigma, Q9.40. Add 2^(S-1), where S = 40-(OUT_W-5) (S=29 at OUT_W=16). Arithmetic shift right by S.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- sat_cnt: +1 per clamped channel sample, so +2 if both clamp. Holds at 0xFFFF. Cleared only by reset.
- FIFO: first-word-fall-through. Simultaneous push and pop at full or empty is legal. The credit rule makes overflow impossible. Pop with out_valid=0 is ignored.
- Reset, asynchronous at any time:
  - state=IDLE; FIFO empty; v1=v2=0.
  - core_ce=0, seed_load=0, out_valid=0, x0=x1=0, sat_cnt=0, busy=0.
  - Latched sigma=0x1000.

## Timing
- Capture at edge of cycle c. Stage 1 is valid in c+1, stage 2 in c+2. The FIFO write makes out_valid=1 in c+3 when the FIFO was empty.
- Start latency, en rising in cycle t:
  - seed_load in t+1.
  - FILL occupies t+2..t+PIPE_LAT+1.
  - First capture at t+PIPE_LAT+2.
  - First out_valid at t+PIPE_LAT+5.
- Throughput is 1 pair per cycle while out_ready=1.
- With out_ready=0, at most FIFO_DEPTH pairs accumulate. core_ce then drops in the cycle after count+v1+v2 reaches FIFO_DEPTH. Capture resumes the cycle after a pop.
- x0/x1 are driven from FIFO storage; they change only on a pop or on a write into an empty FIFO.

## Structure
- Package awgn_pkg:
  - State enum: IDLE, SEED, FILL, RUN.
  - Input Q-format widths: G_W=16, F_W=17, SIGMA_W=16.
  - Constant function for S(OUT_W).
  - Saturation helper function.
- Sub-module awgn_fifo: synchronous FWFT FIFO, parameters WIDTH=2·OUT_W and DEPTH, with count output.
- FSM, credit logic, two-stage multiplier pipeline and sat_cnt live in the top.

## Test plan
- Reset with en=1 and out_ready=1 → all outputs 0. Release, then check: seed_load pulses exactly once; no capture during the 10 FILL cycles; first out_valid arrives 15 cycles after en rises.
- g0=0x4000, g1=0xC000, f=0x4000, sigma=0x1000 → x0=0x0800, x1=0xF800, sat_cnt=0.
- g0=0x7FFF, g1=0x8000, f=0x1FFFF, sigma=0xFFFF → x0=0x7FFF, x1=0x8000, sat_cnt +2 per beat. Hold for 40000 beats → sat_cnt=0xFFFF.
- Back-pressure: out_ready=0 for 50 cycles in RUN → exactly 8 pairs buffered, never overflowing, with core_ce=0 while full. Then out_ready=1 → samples are in core order, no loss or duplication, and sustained 1 beat per cycle.
- Stop and restart: en=0 mid-RUN → the 2 in-flight pairs still appear, then busy=0. Re-enable with the same core seeds → output sequence identical to the first run.
- Asynchronous reset asserted mid-RUN with a full FIFO → out_valid=0, core_ce=0 and FIFO empty immediately, with no clock edge needed.
